multdiv_hilo: RTL
=================

Name: multdiv_hilo

Overview:
- Iterative multiply/divide unit in the EX stage of the MultDiv extension.
- Owns the HI/LO architectural registers. Consumes the HI/LO control fields carried by the ID/EX pipeline register.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles, serves MFHI/MFLO reads, and raises a stall request. The hazard unit turns that request into the ID/EX hold (IEWrite) so a dependent or new HI/LO operation waits for completion.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH. The counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high. Clears all state on the rising edge where it is sampled high.
- start  input  1  HLWrite from ID/EX: issue a mult/div operation.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a  input  WIDTH  rs operand; multiplicand or dividend.
- src_b  input  WIDTH  rt operand; multiplier or divisor.
- hl_read  input  1  HLRead from ID/EX: MFHI/MFLO in EX.
- hl_sel  input  1  HLSrc from ID/EX: 1 = HI, 0 = LO.
- hl_rdata  output  WIDTH  selected HI or LO; combinational from registers.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress; high when state != IDLE.
- stall  output  1  hold request to the hazard unit, combinational: busy & (start | hl_read).

Behaviour:
- Reset:
  - state = IDLE, counter = 0.
  - hi = lo = 0, all internal operand and accumulator registers = 0.
  - busy = 0, stall = 0, hl_rdata = 0.
  - Reset mid-operation aborts the operation; HI/LO read 0 on the next cycle.
- State machine IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - If start=1 at an edge, latch op, latch the operand magnitudes, and record the result signs.
  - For signed ops, magnitude is the two's-complement absolute value. 0x80000000 is kept as unsigned 0x80000000.
  - Then clear the counter and go to CALC. If start=0, stay in IDLE.
- CALC: one iteration per cycle for WIDTH cycles (counter 0..WIDTH-1). Leave to FIX on the edge where counter == WIDTH-1.
  - Multiply is shift-add over a 2*WIDTH-bit product.
  - Divide is restoring: shift the remainder/quotient pair, trial-subtract the divisor, set the quotient bit if there is no borrow.
- FIX: one cycle of sign correction, then write HI/LO on its edge and return to IDLE.
  - MULT: product negated if the operand signs differ. HI = upper WIDTH bits, LO = lower WIDTH bits.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - Division by zero (src_b == 0, any div op): LO = all ones, HI = original src_a. Full latency is still used.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Latency: with start accepted at edge E, busy is high for the next WIDTH+1 cycles. New HI/LO is visible in the cycle after the FIX edge, which is WIDTH+2 cycles after E.
- hi/lo hold their value at all times except the FIX-edge write and reset.
- Handshake:
  - start or hl_read while busy -> stall=1, and the command is ignored (not queued).
  - The pipeline holds ID/EX, so the same start/hl_read is re-presented.
  - Once the unit is IDLE, stall drops the same cycle and the held command is accepted or served.
- hl_read while IDLE: hl_rdata = hl_sel ? hi : lo, no stall. A read issued in the first IDLE cycle after FIX returns the new value.
- start and hl_read high together in IDLE: the read returns the pre-operation value and the operation starts.
- start is never accepted while busy, so back-to-back operations are separated by at least one IDLE cycle.

Test Plan:
- Reset then idle read: rst=1 for 2 cycles, then hl_read=1 with hl_sel=0 and 1 -> hl_rdata=0, busy=0, stall=0.
- MULTU: 0xFFFFFFFF x 0x2 -> busy high for 33 cycles; then hi=0x00000001, lo=0xFFFFFFFE.
- MULT: 0xFFFFFFFD (-3) x 0x7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV: -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall/reissue: MFLO (hl_read=1) held from the cycle after MULTU 6x7 is issued -> stall=1 for all busy cycles; stall=0 and hl_rdata=42 in the first IDLE cycle.
- Second start held during busy: accepted on the first IDLE cycle.
- Reset mid-op: rst asserted in CALC cycle 10 -> next cycle state IDLE, busy=0, hi=lo=0.
- Later start: the op completes normally, with no residue from the aborted operation.

Source files
------------

// File: rtl/multdiv_hilo.sv
// rtl/multdiv_hilo.sv - iterative multiply/divide unit owning the HI/LO registers
module multdiv_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hl_read,
   input  logic             hl_sel,
   output logic [WIDTH-1:0] hl_rdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_orig;
   logic [2*WIDTH-1:0] acc;

   // Operand magnitudes; the most negative value maps onto itself as unsigned.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   assign a_neg = op[0] & src_a[WIDTH-1];
   assign b_neg = op[0] & src_b[WIDTH-1];
   assign a_abs = a_neg ? -src_a : src_a;
   assign b_abs = b_neg ? -src_b : src_b;

   // Shift-add step: acc holds {partial product, remaining multiplier bits}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Restoring step: acc holds {remainder, dividend/quotient bits}.
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;
   assign div_shift = acc[2*WIDTH-1:WIDTH-1];
   assign div_ge    = div_shift >= {1'b0, opnd};
   assign div_diff  = div_shift[WIDTH-1:0] - opnd;
   assign div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                             : {acc[2*WIDTH-2:0], 1'b0};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod_fix = neg_res ? -acc : acc;
   assign quo_fix  = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
   assign rem_fix  = div_zero ? a_orig
                              : (neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         opnd     <= '0;
         a_orig   <= '0;
         acc      <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= op[1] & (src_b == '0);
                  opnd     <= op[1] ? b_abs : a_abs;
                  acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                  a_orig   <= src_a;
                  cnt      <= '0;
               end
            end
            CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign stall    = busy & (start | hl_read);
   assign hl_rdata = hl_sel ? hi : lo;

endmodule
